// File: rtl/decoder_pkg.sv
// Shared types, mode encodings and the one-hot helper for the decoder_scan block.
// Sized for the widest legal select (5 bits, 32 outputs); callers cast down to their width.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 5;
    localparam int MAX_OUT_W = 32;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        onehot = MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable (generalised 2x4 decoder).
// A low enable forces the all-zero code.
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  en_i,
    output logic [2**SEL_W-1:0]   y_o
);

    localparam int OUT_W = 2**SEL_W;

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o = OUT_W'(onehot(MAX_SEL_W'(sel_i)));
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a direct mode and an autonomous scan sequencer.
// State is visible through busy (high exactly while in SCAN); legal SEL_W is 1..5.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  load,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output logic                  busy
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = {SEL_W{1'b1}};

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [OUT_W-1:0]     y_q, y_d;
    logic                 wrap_q, wrap_d;
    logic                 busy_q, busy_d;
    logic                 dec_en;

    // One decoder serves both paths: it always decodes the next index, gated by dec_en.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel_i (idx_d),
        .en_i  (dec_en),
        .y_o   (y_d)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        dec_en  = 1'b0;

        // Direct mode wins in either state; load then has priority over a scheduled advance.
        if (mode == MODE_DIRECT) begin
            state_d = IDLE;
            idx_d   = sel;
            dec_en  = en;
        end else if (load) begin
            state_d = SCAN;
            idx_d   = sel;
            dwell_d = dwell;
            cnt_d   = '0;
            dec_en  = en;
        end else begin
            case (state_q)
                IDLE: begin
                    dec_en = 1'b0;
                end
                SCAN: begin
                    // en low blanks the output and freezes both index and dwell count.
                    if (en) begin
                        dec_en = 1'b1;
                        if (cnt_q == dwell_q) begin
                            cnt_d  = '0;
                            idx_d  = idx_q + SEL_W'(1);
                            wrap_d = (idx_q == LAST_IDX);
                        end else begin
                            cnt_d = cnt_q + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: SEL_W=2 main instance plus SEL_W=3 and SEL_W=1 scan instances.
module tb_decoder_scan;

    logic       clk;
    logic       rst_n;

    logic       en, mode, load;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap, busy;

    logic       en3, mode3, load3;
    logic [2:0] sel3;
    logic [7:0] dwell3;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       wrap3, busy3;

    logic       en1, mode1, load1;
    logic [0:0] sel1;
    logic [7:0] dwell1;
    logic [1:0] y1;
    logic [0:0] idx1;
    logic       wrap1, busy1;

    int errors = 0;
    int checks = 0;
    int n;
    int wraps;

    logic [3:0] direct_exp [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] scan_exp   [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                    4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    logic       scan_wrap  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] alt_exp    [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic       alt_wrap   [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};

    decoder_scan #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .dwell(dwell), .y(y), .idx(idx), .wrap(wrap), .busy(busy)
    );

    decoder_scan #(.SEL_W(3), .DWELL_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel(sel3), .load(load3),
        .dwell(dwell3), .y(y3), .idx(idx3), .wrap(wrap3), .busy(busy3)
    );

    decoder_scan #(.SEL_W(1), .DWELL_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel(sel1), .load(load1),
        .dwell(dwell1), .y(y1), .idx(idx1), .wrap(wrap1), .busy(busy1)
    );

    // Clock and bounded run time
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs of every instance must be zero or one-hot in every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (($onehot0(y) && $onehot0(y3) && $onehot0(y1)) === 1'b1) else begin
                errors++;
                $error("FAIL onehot0 observed y=%b y3=%b y1=%b expected zero or one-hot", y, y3, y1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0; mode = 1'b0; load = 1'b0; sel = 2'd0; dwell = 8'd0;
        en3 = 1'b0; mode3 = 1'b0; load3 = 1'b0; sel3 = 3'd0; dwell3 = 8'd0;
        en1 = 1'b0; mode1 = 1'b0; load1 = 1'b0; sel1 = 1'b0; dwell1 = 8'd0;

        #3;
        chk("reset_y", 32'(y), 32'h0);
        chk("reset_idx", 32'(idx), 32'h0);
        chk("reset_wrap", 32'(wrap), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;

        // Direct decode, one cycle latency
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            chk($sformatf("direct_y_%0d", s), 32'(y), 32'(direct_exp[s]));
            chk($sformatf("direct_idx_%0d", s), 32'(idx), 32'(s));
        end
        en = 1'b0;
        tick();
        chk("direct_blank", 32'(y), 32'h0);

        // Scan from channel 1 with dwell 2
        en = 1'b1; mode = 1'b1; sel = 2'd1; dwell = 8'd2; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            chk($sformatf("scan_y_%0d", i), 32'(y), 32'(scan_exp[i]));
            chk($sformatf("scan_wrap_%0d", i), 32'(wrap), 32'(scan_wrap[i]));
            chk($sformatf("scan_busy_%0d", i), 32'(busy), 32'h1);
        end

        // Pause on the second cycle of channel 2, dwell 3
        sel = 2'd2; dwell = 8'd3; load = 1'b1;
        tick();
        load = 1'b0;
        chk("pause_first", 32'(y), 32'h4);
        tick();
        chk("pause_second", 32'(y), 32'h4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("pause_y_%0d", i), 32'(y), 32'h0);
            chk($sformatf("pause_idx_%0d", i), 32'(idx), 32'h2);
        end
        en = 1'b1;
        tick();
        chk("resume_a", 32'(y), 32'h4);
        tick();
        chk("resume_b", 32'(y), 32'h4);
        tick();
        chk("resume_adv_y", 32'(y), 32'h8);
        chk("resume_adv_idx", 32'(idx), 32'h3);

        // Load on the cycle a wrapping advance is due
        tick();
        tick();
        tick();
        sel = 2'd3; dwell = 8'd0; load = 1'b1;
        tick();
        load = 1'b0;
        chk("restart_idx", 32'(idx), 32'h3);
        chk("restart_y", 32'(y), 32'h8);
        chk("restart_wrap", 32'(wrap), 32'h0);
        tick();
        chk("restart_next_y", 32'(y), 32'h1);
        chk("restart_next_wrap", 32'(wrap), 32'h1);
        tick();
        chk("restart_after_y", 32'(y), 32'h2);
        chk("restart_after_wrap", 32'(wrap), 32'h0);

        // Abort to direct mode
        mode = 1'b0; sel = 2'd2;
        tick();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_y", 32'(y), 32'h4);
        chk("abort_wrap", 32'(wrap), 32'h0);

        // Asynchronous reset mid-scan
        mode = 1'b1; sel = 2'd1; dwell = 8'd5; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("prereset_busy", 32'(busy), 32'h1);
        chk("prereset_y", 32'(y), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_y", 32'(y), 32'h0);
        chk("async_idx", 32'(idx), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_wrap", 32'(wrap), 32'h0);
        rst_n = 1'b1;
        mode = 1'b0; sel = 2'd3;
        tick();
        chk("post_reset_direct", 32'(y), 32'h8);

        // Scan mode without load: hold index, blank output
        mode = 1'b1;
        tick();
        chk("idle_scan_y", 32'(y), 32'h0);
        chk("idle_scan_idx", 32'(idx), 32'h3);
        chk("idle_scan_busy", 32'(busy), 32'h0);

        // All-ones dwell holds a channel 256 cycles
        sel = 2'd0; dwell = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        while (y === 4'b0001 && n < 300) begin
            n++;
            tick();
        end
        chk("max_dwell_len", 32'(n), 32'd256);
        chk("max_dwell_next", 32'(y), 32'h2);

        // SEL_W=3, dwell 0, full walk twice
        en3 = 1'b1; mode3 = 1'b1; sel3 = 3'd0; dwell3 = 8'd0; load3 = 1'b1;
        tick();
        load3 = 1'b0;
        wraps = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) tick();
            chk($sformatf("w8_y_%0d", i), 32'(y3), 32'h1 << (i % 8));
            chk($sformatf("w8_wrap_%0d", i), 32'(wrap3), 32'((i % 8 == 0) && (i > 0)));
            if (wrap3) wraps++;
        end
        chk("w8_wrap_count", 32'(wraps), 32'd2);

        // SEL_W=1 alternates
        en1 = 1'b1; mode1 = 1'b1; sel1 = 1'b0; dwell1 = 8'd0; load1 = 1'b1;
        tick();
        load1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk($sformatf("w2_y_%0d", i), 32'(y1), 32'(alt_exp[i]));
            chk($sformatf("w2_wrap_%0d", i), 32'(wrap1), 32'(alt_wrap[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
